// File: rtl/led_pkg.sv
// ============================================================================
// Module      : led_pkg
// Description : Shared defaults and the brightness type for the LED PWM stage.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package led_pkg;

  localparam int N_LEDS_DEF      = 8;
  localparam int PWM_W_DEF       = 8;
  localparam int DECAY_SHIFT_DEF = 1;

  typedef logic [PWM_W_DEF-1:0] brightness_t;

endpackage

`default_nettype wire

// File: rtl/led_pwm_channel.sv
// ============================================================================
// Module      : led_pwm_channel
// Description : One LED: decaying shadow brightness, period-latched active
//               brightness and the PWM comparator.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module led_pwm_channel
  import led_pkg::*;
#(
  parameter int PWM_W       = PWM_W_DEF,
  parameter int DECAY_SHIFT = DECAY_SHIFT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] cnt_i,
  input  logic             boundary_i,
  input  logic             step_i,
  input  logic             led_i,
  output logic             pwm_o
);

  localparam logic [PWM_W-1:0] MAX_BRIGHT = '1;

  logic [PWM_W-1:0] shadow_q, shadow_d;
  logic [PWM_W-1:0] active_q, active_d;
  logic             pwm_q;

  always_comb begin
    shadow_d = shadow_q;
    if (step_i) begin
      shadow_d = led_i ? MAX_BRIGHT : (shadow_q >> DECAY_SHIFT);
    end
    // A step landing on the boundary cycle is forwarded straight into active.
    active_d = boundary_i ? shadow_d : active_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= (active_q > cnt_i);
    end
  end

  assign pwm_o = pwm_q;

endmodule

`default_nettype wire

// File: rtl/led_trail_pwm.sv
// ============================================================================
// Module      : led_trail_pwm
// Description : Comet-tail PWM driver: shared period counter plus one
//               decaying-brightness channel per LED.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module led_trail_pwm
  import led_pkg::*;
#(
  parameter int N_LEDS      = N_LEDS_DEF,
  parameter int PWM_W       = PWM_W_DEF,
  parameter int DECAY_SHIFT = DECAY_SHIFT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic [N_LEDS-1:0] led_in,
  output logic [N_LEDS-1:0] pwm_out,
  output logic              period_start
);

  logic [PWM_W-1:0] cnt_q;
  logic             period_start_q;
  logic             boundary;

  assign boundary = (cnt_q == '1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_q + 1'b1;
      period_start_q <= (cnt_q == '0);
    end
  end

  assign period_start = period_start_q;

  generate
    for (genvar g = 0; g < N_LEDS; g++) begin : g_chan
      led_pwm_channel #(
        .PWM_W       (PWM_W),
        .DECAY_SHIFT (DECAY_SHIFT)
      ) u_chan (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt_i      (cnt_q),
        .boundary_i (boundary),
        .step_i     (step),
        .led_i      (led_in[g]),
        .pwm_o      (pwm_out[g])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_led_trail_pwm.sv
// ============================================================================
// Module      : tb_led_trail_pwm
// Description : Directed and randomized bench for led_trail_pwm with a
//               period-level brightness reference model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_led_trail_pwm;
  import led_pkg::*;

  localparam int N_LEDS = N_LEDS_DEF;
  localparam int PWM_W  = PWM_W_DEF;
  localparam int DS     = DECAY_SHIFT_DEF;
  localparam int PERIOD = 1 << PWM_W;
  localparam int MAXV   = PERIOD - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              step = 1'b0;
  logic [N_LEDS-1:0] led_in = '0;
  logic [N_LEDS-1:0] pwm_out;
  logic              period_start;

  led_trail_pwm #(
    .N_LEDS      (N_LEDS),
    .PWM_W       (PWM_W),
    .DECAY_SHIFT (DS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .step         (step),
    .led_in       (led_in),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: phase within the period, pending brightness per LED, and the
  // brightness governing the period currently being emitted.
  int                jc;
  int                shadow_m [N_LEDS];
  brightness_t       duty_m   [N_LEDS];
  logic [N_LEDS-1:0] exp_pwm;
  logic              exp_ps;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input bit rn, input bit st, input logic [N_LEDS-1:0] led);
    @(negedge clk);
    rst_n  = rn;
    step   = st;
    led_in = led;
    @(posedge clk);
    if (!rn) begin
      jc      = 0;
      exp_pwm = '0;
      exp_ps  = 1'b0;
      for (int i = 0; i < N_LEDS; i++) begin
        shadow_m[i] = 0;
        duty_m[i]   = '0;
      end
    end else begin
      for (int i = 0; i < N_LEDS; i++) exp_pwm[i] = (jc < int'(duty_m[i]));
      exp_ps = (jc == 0);
      if (st) begin
        for (int i = 0; i < N_LEDS; i++)
          shadow_m[i] = led[i] ? MAXV : shadow_m[i] / (1 << DS);
      end
      if (jc == MAXV) begin
        for (int i = 0; i < N_LEDS; i++) duty_m[i] = brightness_t'(shadow_m[i]);
      end
      jc = (jc + 1) % PERIOD;
    end
    #1;
    check("pwm_out", 32'(pwm_out), 32'(exp_pwm));
    check("period_start", 32'(period_start), 32'(exp_ps));
  endtask

  task automatic run_to(input int c);
    while (jc != c) cycle(1'b1, 1'b0, '0);
  endtask

  task automatic step_at(input int c, input logic [N_LEDS-1:0] led);
    run_to(c);
    cycle(1'b1, 1'b1, led);
  endtask

  // Count high cycles of every LED over one whole period starting at cnt==0.
  task automatic measure(output int hi [N_LEDS]);
    run_to(0);
    for (int i = 0; i < N_LEDS; i++) hi[i] = 0;
    repeat (PERIOD) begin
      cycle(1'b1, 1'b0, '0);
      for (int i = 0; i < N_LEDS; i++) hi[i] += int'(pwm_out[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi [N_LEDS];
    int exp_decay [9];
    exp_decay = '{127, 63, 31, 15, 7, 3, 1, 0, 0};
    jc = 0;
    for (int i = 0; i < N_LEDS; i++) begin
      shadow_m[i] = 0;
      duty_m[i]   = '0;
    end

    // Reset held 3 cycles; the steps offered meanwhile must be discarded.
    repeat (3) cycle(1'b0, 1'b1, '1);
    check("rst_pwm", 32'(pwm_out), 32'h0);
    check("rst_ps", 32'(period_start), 32'h0);
    cycle(1'b1, 1'b0, '0);
    check("ps_cycle2", 32'(period_start), 32'h1);
    cycle(1'b1, 1'b0, '0);
    check("ps_cycle3", 32'(period_start), 32'h0);

    // Light LED0 mid-period, then one decay step per period.
    step_at(100, 8'h01);
    measure(hi);
    check("light_hi0", 32'(hi[0]), 32'd255);
    for (int k = 0; k < 9; k++) begin
      step_at(50, 8'h00);
      measure(hi);
      check("decay_hi0", 32'(hi[0]), 32'(exp_decay[k]));
    end

    // Two steps in one period compound.
    step_at(10, 8'h01);
    step_at(20, 8'h00);
    measure(hi);
    check("compound_hi0", 32'(hi[0]), 32'd127);
    for (int i = 1; i < N_LEDS; i++) check("compound_other", 32'(hi[i]), 32'd0);

    // Step on the boundary cycle reaches the very next period.
    step_at(MAXV, 8'h80);
    measure(hi);
    check("bypass_hi7", 32'(hi[7]), 32'd255);
    check("bypass_hi0", 32'(hi[0]), 32'd63);

    // One-cycle reset mid-period with several channels lit.
    step_at(100, 8'hA5);
    run_to(37);
    cycle(1'b0, 1'b0, '0);
    check("midrst_pwm", 32'(pwm_out), 32'h0);
    measure(hi);
    for (int i = 0; i < N_LEDS; i++) check("midrst_hi", 32'(hi[i]), 32'd0);

    // Random steps and patterns, including occasional boundary-cycle steps.
    repeat (6 * PERIOD) begin
      bit s;
      s = ($urandom_range(0, 31) == 0) || (jc == MAXV && $urandom_range(0, 3) == 0);
      cycle(1'b1, s, N_LEDS'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_trail_pwm.md
# led_trail_pwm

Downstream stage of the LED scanner: consumes the 8-bit scan pattern and drives each physical LED with a PWM signal whose brightness jumps to full when the LED's pattern bit is lit. Once the bit is no longer lit, the brightness decays geometrically at each pattern step, which produces a fading "comet tail" behind the moving pair. Brightness changes are applied only at PWM period boundaries, so no output glitches mid-period.

## Interface

- N_LEDS, 8, number of LED channels
- PWM_W, 8, PWM counter and brightness width; period = 2^PWM_W cycles
- DECAY_SHIFT, 1, right-shift applied to an unlit channel's brightness per step
- clk  input  1  single system clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- step  input  1  one-cycle pulse: sample led_in and advance the decay
- led_in  input  N_LEDS  scan pattern from the scanner stage (bit i = LED i lit)
- pwm_out  output  N_LEDS  registered PWM drive, one bit per LED
- period_start  output  1  registered one-cycle pulse on the first pwm_out cycle of each period

## Operation

- Per-channel state: shadow[i] and active[i], both PWM_W bits. MAX = 2^PWM_W-1.
- cnt: free-running PWM_W-bit up-counter, wraps MAX->0.
- On step: shadow[i] <= led_in[i] ? MAX : shadow[i] >> DECAY_SHIFT. The decay uses the current shadow, so multiple steps within one period compound.
- At period boundary (cycle with cnt==MAX): active[i] <= shadow[i].
  - If step occurs in that same cycle, active takes the newly computed shadow value (bypass).
- pwm_out[i] <= (active[i] > cnt). Duty = active/2^PWM_W.
  - MAX gives 255/256 duty (low only at cnt==MAX).
  - 0 gives a constant low.
- period_start <= (cnt==0).
- led_in is ignored when step is low. led_in values wider than N_LEDS are not applicable; all bits are used.
- Reset (rst_n low at a clock edge):
  - cnt, shadow, active, pwm_out and period_start all go to 0.
  - Reset mid-period aborts the period; counting restarts from 0 on the first cycle with rst_n high.

## Timing

- Output latency: pwm_out and period_start reflect cnt from the previous cycle (1-cycle register).
- First cycle after reset release: cnt=0. Next cycle: period_start=1, pwm_out=0.
- Step-to-output latency: a step in cycle t of a period becomes visible from that period's next boundary. It is visible 1 cycle after cnt returns to 0 (the period_start cycle) and lasts the full following period.
- Step in the cnt==MAX cycle: takes effect in the immediately following period.
- A step during reset is discarded.

## Structure

- Shared package led_pkg:
  - default N_LEDS / PWM_W / DECAY_SHIFT constants;
  - a brightness_t typedef (PWM_W-bit).
- One natural sub-module: led_pwm_channel, holding shadow, active and the comparator for one LED. It takes cnt, the boundary strobe, step and led_in[i]. It is instantiated N_LEDS times in a generate loop.
- cnt and period_start live in the top level.

## Test plan

Defaults assumed: PWM_W=8, DECAY_SHIFT=1.

- Reset: hold rst_n low 3 cycles -> pwm_out=0x00, period_start=0. After release, period_start pulses on cycle 2, then every 256 cycles.
- Lighting a channel: step with led_in=0x01 at cnt=100 -> pwm_out[0] stays 0 for the rest of that period. From the next period_start it is high 255 cycles, then low 1 cycle, per period.
- Decay: after full-on, apply one step per period with led_in=0x00 -> pwm_out[0] high-cycle counts per period are 127, 63, 31, 15, 7, 3, 1, 0, 0.
- Boundary bypass: step with led_in=0x80 in the cycle cnt==255 -> pwm_out[7] high for 255 cycles starting at the very next period_start.
- Compounding steps: within one period, step led_in=0x01 then step led_in=0x00 -> next period pwm_out[0] high exactly 127 cycles. Other bits remain 0.
- Reset mid-operation: with several channels active, drop rst_n for 1 cycle at cnt=37 -> pwm_out=0x00 the next cycle. cnt restarts, and all brightness stays 0 until a new step occurs.
